spi_monitor_bridge: RTL and testbench
=====================================

// Module: spi_monitor_bridge
// PURPOSE
//  Parametrised bus monitor <-> host MCU bridge over SPI slave (mode 1, LSB first), fully synchronous to MCLK_IN.
//  Each frame ships a snapshot of ADDR/DATA/OUTPUT_SIGNAL plus one queued UART byte to the host.
//  Each frame also returns INPUT_SIGNAL plus one UART byte from the host.
//  Adds per-direction byte FIFOs, valid/ready handshakes, sticky overflow flag and abort-safe frame commit.
// PARAMETERS
//  ADDR_W      24  monitored address width
//  DATA_W      16  monitored data width
//  OUT_W       4   OUTPUT_SIGNAL_IN width
//  IN_W        4   INPUT_SIGNAL width
//  TX_DEPTH    4   send FIFO depth in bytes; power of 2, >=2
//  RX_DEPTH    4   receive FIFO depth in bytes; power of 2, >=2
//  SYNC_STAGES 2   synchroniser flops on SPICLK/SPISI/SPISS; >=2
// PORTS
//  MCLK_IN             in   1       system clock; must be >= 8x SPICLK
//  RUN_IN              in   1       async active-low reset
//  SPICLK_IN           in   1       SPI clock from host, asynchronous
//  SPISI_IN            in   1       MOSI
//  SPISS_IN            in   1       slave select, active low
//  ADDR_IN             in   ADDR_W  monitored address
//  DATA_IN             in   DATA_W  monitored data
//  OUTPUT_SIGNAL_IN    in   OUT_W   signals reported to host
//  UART_SEND_VALID_IN  in   1       CPU offers UART_SEND_BYTE_IN
//  UART_SEND_BYTE_IN   in   8       byte to host
//  UART_SEND_READY     out  1       send FIFO not full
//  UART_RECEIVE_READY_IN in 1       CPU pops receive FIFO head
//  UART_RECEIVE_VALID  out  1       receive FIFO not empty
//  UART_RECEIVE_BYTE   out  8       receive FIFO head (valid when VALID=1)
//  INPUT_SIGNAL        out  IN_W    signals from host, updated per committed frame
//  SPISO               out  1       MISO; 1'bz while slave not selected
//  RX_OVERFLOW         out  1       sticky: host byte dropped because receive FIFO was full
//  FRAME_DONE          out  1       one-cycle pulse per committed frame
// BEHAVIOUR
//  Reset (RUN_IN=0): FIFOs emptied, shift regs/bit count 0, INPUT_SIGNAL=0, RX_OVERFLOW=0, FRAME_DONE=0, SPISO=z,
//   UART_SEND_READY=1, UART_RECEIVE_VALID=0, UART_RECEIVE_BYTE=0. Reset mid-frame discards the frame.
//  SPI inputs pass through SYNC_STAGES flops; edges are detected on synchronised SPICLK. Latency pin->action <= SYNC_STAGES+1 clocks.
//  MISO frame, LSB first, FRAME_BITS = ADDR_W+DATA_W+OUT_W+4+8 (56 at defaults):
//   ADDR | DATA | OUT | TX_VALID | RX_FULL | RX_OVF | 0 | TX_BYTE.
//  MOSI frame, LSB first, MOSI_BITS = IN_W+4+8; bits beyond MOSI_BITS ignored:
//   IN | RX_VALID | HOST_FULL | CLR_OVF | 0 | RX_BYTE.
//  FSM IDLE -> SHIFT -> (COMMIT | ABORT) -> IDLE.
//   IDLE: on synced SS fall, snapshot ADDR/DATA/OUT/flags/TX head into MISO shifter, count=0, go SHIFT.
//   SHIFT: SCLK rise drives next MISO bit (first rise drives bit0); SCLK fall samples MOSI and increments count (saturates).
//   SS rise with count >= FRAME_BITS -> COMMIT; SS rise with count < FRAME_BITS -> ABORT.
//   COMMIT and ABORT each last 1 clock, then IDLE.
//  TX_VALID = send FIFO non-empty AND HOST_FULL from last committed frame == 0; TX_BYTE = head, else 0.
//  RX_FULL = receive FIFO full at snapshot; RX_OVF = RX_OVERFLOW at snapshot.
//  COMMIT:
//   INPUT_SIGNAL <= IN bits; FRAME_DONE=1; latch HOST_FULL.
//   Pop send FIFO iff TX_VALID was sent as 1.
//   If RX_VALID: push RX_BYTE, or if FIFO full drop it and set RX_OVERFLOW.
//   CLR_OVF clears RX_OVERFLOW; set wins over clear in the same commit.
//  ABORT: no FIFO pop/push, INPUT_SIGNAL and flags unchanged; the byte is resent next frame.
//  FIFOs: push when VALID&READY; simultaneous push+pop allowed at any occupancy except push is refused when full.
//   No fall-through: a byte pushed in cycle N is visible at FIFO output in cycle N+1.
// STRUCTURE
//  Shared package monitor_pkg: flag bit offsets (TX_VALID/RX_FULL/RX_OVF, RX_VALID/HOST_FULL/CLR_OVF),
//   FSM state encodings, frame-length functions.
//  Sub-module monitor_byte_fifo (8-bit, DEPTH param, valid/ready both sides, full/empty), instantiated twice.
//  Top holds synchronisers, edge detect, FSM, MISO/MOSI shifters.
// TESTING
//  1 Reset then idle frame, ADDR=0xABCDEF, DATA=0x1234, OUT=0x5, MOSI IN=0xA:
//    MISO = EF CD AB 34 12 05 00 (LSB first); INPUT_SIGNAL=0xA after FRAME_DONE.
//  2 Push 0x41,0x42 from CPU; run 2 frames:
//    TX_VALID=1 with bytes 0x41 then 0x42; third frame TX_VALID=0; READY=0 only after TX_DEPTH pushes without frames.
//  3 Abort after 20 SCLKs while 0x41 queued: no FRAME_DONE, INPUT_SIGNAL unchanged; next full frame resends 0x41.
//  4 Host sends RX_VALID with 0x55 for RX_DEPTH+1 frames, CPU never pops:
//    RX_FULL=1 from frame RX_DEPTH+1; RX_OVERFLOW set; CLR_OVF frame clears it.
//  5 HOST_FULL=1 in a frame with bytes queued: next frame TX_VALID=0 and no pop; HOST_FULL=0 resumes.
//  6 RUN_IN low mid-frame with both FIFOs non-empty: all outputs return to reset values; SPISO=z.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared definitions for the SPI monitor bridge.
// Flag offsets, FSM states and frame-length helpers.
package monitor_pkg;

    localparam int BYTE_W = 8;
    localparam int FLAG_W = 4;

    // Flag nibble offsets in the slave-to-host frame
    localparam int MISO_TXV = 0;
    localparam int MISO_RXF = 1;
    localparam int MISO_OVF = 2;

    // Flag nibble offsets in the host-to-slave frame
    localparam int MOSI_RXV   = 0;
    localparam int MOSI_HFULL = 1;
    localparam int MOSI_CLR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ABORT  = 2'd3
    } state_e;

    function automatic int frame_bits(
        input int aw,
        input int dw,
        input int ow
    );
        return aw + dw + ow + FLAG_W + BYTE_W;
    endfunction

    function automatic int mosi_bits(input int iw);
        return iw + FLAG_W + BYTE_W;
    endfunction

endpackage

// File: rtl/spi_monitor_bridge_if.sv
// CPU-side UART byte handshakes of the monitor bridge.
// master = CPU, slave = bridge.
interface spi_monitor_bridge_if;

    logic       UART_SEND_VALID_IN;
    logic [7:0] UART_SEND_BYTE_IN;
    logic       UART_SEND_READY;
    logic       UART_RECEIVE_READY_IN;
    logic       UART_RECEIVE_VALID;
    logic [7:0] UART_RECEIVE_BYTE;

    modport master (
        output UART_SEND_VALID_IN,
        output UART_SEND_BYTE_IN,
        input  UART_SEND_READY,
        output UART_RECEIVE_READY_IN,
        input  UART_RECEIVE_VALID,
        input  UART_RECEIVE_BYTE
    );

    modport slave (
        input  UART_SEND_VALID_IN,
        input  UART_SEND_BYTE_IN,
        output UART_SEND_READY,
        input  UART_RECEIVE_READY_IN,
        output UART_RECEIVE_VALID,
        output UART_RECEIVE_BYTE
    );

endinterface

// File: rtl/monitor_byte_fifo.sv
// Byte FIFO with valid/ready on both sides, no fall-through.
// Push is refused when full even if a pop happens in the same cycle.
module monitor_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    input  logic       out_ready_i,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        push;
    logic        pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);

    assign in_ready_o  = ~full_o;
    assign out_valid_o = ~empty_o;
    assign out_data_o  = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // Pointer advance on accepted push / pop
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; contents are don't-care while empty
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q[AW-1:0]] <= in_data_i;
    end

endmodule

// File: rtl/spi_monitor_bridge.sv
// Bus monitor <-> host MCU bridge over an SPI mode-1 slave.
// Frames are LSB first; FIFO effects land only on a full frame.
module spi_monitor_bridge
    import monitor_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int OUT_W       = 4,
    parameter int IN_W        = 4,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              MCLK_IN,
    input  logic              RUN_IN,
    input  logic              SPICLK_IN,
    input  logic              SPISI_IN,
    input  logic              SPISS_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [OUT_W-1:0]  OUTPUT_SIGNAL_IN,
    spi_monitor_bridge_if.slave uart,
    output logic [IN_W-1:0]   INPUT_SIGNAL,
    output wire               SPISO,
    output logic              RX_OVERFLOW,
    output logic              FRAME_DONE
);

    localparam int FB    = frame_bits(ADDR_W, DATA_W, OUT_W);
    localparam int MB    = mosi_bits(IN_W);
    localparam int CNT_W = $clog2(FB + 1);
    localparam logic [CNT_W-1:0] FB_C = CNT_W'(FB);
    localparam logic [CNT_W-1:0] MB_C = CNT_W'(MB);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic sclk_prev_q, ss_prev_q;
    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    state_e state_q, state_d;
    logic   commit, start;

    logic [FB-1:0]    miso_sh_q;
    logic             miso_q;
    logic [MB-1:0]    mosi_q;
    logic [CNT_W-1:0] cnt_q;
    logic             txv_sent_q;
    logic [IN_W-1:0]  in_sig_q;
    logic             host_full_q;
    logic             ovf_q;

    logic       tx_rdy, tx_vld, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_rdy, rx_vld, rx_full, rx_empty;
    logic [7:0] rx_head;

    logic            txv_now;
    logic [3:0]      miso_flags;
    logic [FB-1:0]   snap;
    logic [IN_W-1:0] h_in;
    logic            h_rxv, h_hfull, h_clr;
    logic [7:0]      h_byte;
    logic            ovf_set;
    logic            unused_ok;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;

    // Synchronise the asynchronous SPI pins and keep edge history
    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPICLK_IN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPISI_IN};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPISS_IN};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Frame FSM state register
    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Frame FSM next state; a short frame aborts with no side effects
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = (cnt_q >= FB_C) ? ST_COMMIT : ST_ABORT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot contents; host back-pressure suppresses the TX byte
    always_comb begin
        txv_now              = tx_vld & ~host_full_q;
        miso_flags           = '0;
        miso_flags[MISO_TXV] = txv_now;
        miso_flags[MISO_RXF] = rx_full;
        miso_flags[MISO_OVF] = ovf_q;
        snap = {(txv_now ? tx_head : 8'h00), miso_flags,
                OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};
    end

    assign h_in    = mosi_q[IN_W-1:0];
    assign h_rxv   = mosi_q[IN_W+MOSI_RXV];
    assign h_hfull = mosi_q[IN_W+MOSI_HFULL];
    assign h_clr   = mosi_q[IN_W+MOSI_CLR];
    assign h_byte  = mosi_q[IN_W+FLAG_W +: 8];

    // MISO/MOSI shifters and saturating bit counter
    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            miso_sh_q  <= '0;
            miso_q     <= 1'b0;
            mosi_q     <= '0;
            cnt_q      <= '0;
            txv_sent_q <= 1'b0;
        end else if (start) begin
            miso_sh_q  <= snap;
            miso_q     <= 1'b0;
            mosi_q     <= '0;
            cnt_q      <= '0;
            txv_sent_q <= txv_now;
        end else if (state_q == ST_SHIFT) begin
            if (sclk_rise) begin
                miso_q    <= miso_sh_q[0];
                miso_sh_q <= miso_sh_q >> 1;
            end
            if (sclk_fall) begin
                if (cnt_q < MB_C) mosi_q <= {mosi_s, mosi_q[MB-1:1]};
                if (cnt_q != FB_C) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ovf_set = commit & h_rxv & ~rx_rdy;

    // Committed-frame state; overflow set beats clear
    always_ff @(posedge MCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            in_sig_q    <= '0;
            host_full_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (commit) begin
            in_sig_q    <= h_in;
            host_full_q <= h_hfull;
            if (ovf_set)    ovf_q <= 1'b1;
            else if (h_clr) ovf_q <= 1'b0;
        end
    end

    assign tx_pop  = commit & txv_sent_q;
    assign rx_push = commit & h_rxv;

    monitor_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i       (MCLK_IN),
        .rst_ni      (RUN_IN),
        .in_valid_i  (uart.UART_SEND_VALID_IN),
        .in_data_i   (uart.UART_SEND_BYTE_IN),
        .in_ready_o  (tx_rdy),
        .out_valid_o (tx_vld),
        .out_data_o  (tx_head),
        .out_ready_i (tx_pop),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    monitor_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i       (MCLK_IN),
        .rst_ni      (RUN_IN),
        .in_valid_i  (rx_push),
        .in_data_i   (h_byte),
        .in_ready_o  (rx_rdy),
        .out_valid_o (rx_vld),
        .out_data_o  (rx_head),
        .out_ready_i (uart.UART_RECEIVE_READY_IN),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    assign uart.UART_SEND_READY    = tx_rdy;
    assign uart.UART_RECEIVE_VALID = rx_vld;
    assign uart.UART_RECEIVE_BYTE  = rx_head;

    assign INPUT_SIGNAL = in_sig_q;
    assign RX_OVERFLOW  = ovf_q;
    assign FRAME_DONE   = commit;
    assign SPISO        = (state_q == ST_SHIFT) ? miso_q : 1'bz;

    assign unused_ok = ^{tx_full, tx_empty, rx_empty,
                         mosi_q[IN_W+FLAG_W-1]};

endmodule

// File: tb/tb_spi_monitor_bridge.sv
// Directed bench for spi_monitor_bridge at default parameters.
// Host SPI frames are driven bit by bit; MISO is captured and compared.
module tb_spi_monitor_bridge;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic [23:0] addr;
    logic [15:0] data;
    logic [3:0]  outs;
    logic [3:0]  in_sig;
    wire         miso;
    logic        ovf;
    logic        fdone;

    int tests;
    int fails;
    int done_cnt;

    pullup (miso);

    spi_monitor_bridge_if u_if ();

    spi_monitor_bridge dut (
        .MCLK_IN          (clk),
        .RUN_IN           (rst_n),
        .SPICLK_IN        (sclk),
        .SPISI_IN         (mosi),
        .SPISS_IN         (ss),
        .ADDR_IN          (addr),
        .DATA_IN          (data),
        .OUTPUT_SIGNAL_IN (outs),
        .uart             (u_if),
        .INPUT_SIGNAL     (in_sig),
        .SPISO            (miso),
        .RX_OVERFLOW      (ovf),
        .FRAME_DONE       (fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fdone === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] em(input bit txv, input bit rxf,
                                       input bit ov, input logic [7:0] tx);
        return {tx, 1'b0, ov, rxf, txv, 4'h5, 16'h1234, 24'hABCDEF};
    endfunction

    function automatic logic [15:0] mm(input logic [3:0] iv, input bit rxv,
                                       input bit hf, input bit clr,
                                       input logic [7:0] b);
        return {b, 1'b0, clr, hf, rxv, iv};
    endfunction

    task automatic push(input logic [7:0] b);
        u_if.UART_SEND_VALID_IN = 1'b1;
        u_if.UART_SEND_BYTE_IN  = b;
        clks(1);
        u_if.UART_SEND_VALID_IN = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [15:0] mo,
                         input int nbits, input logic [55:0] exp,
                         input bit full);
        int d0;
        logic [55:0] got;
        d0  = done_cnt;
        got = '0;
        ss  = 1'b0;
        clks(6);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? mo[i] : 1'b0;
            sclk = 1'b1;
            clks(8);
            got[i] = miso;
            sclk = 1'b0;
            clks(8);
        end
        ss   = 1'b1;
        mosi = 1'b0;
        clks(8);
        if (full) begin
            chk({tag, "_miso"}, 64'(got), 64'(exp));
            chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        end else begin
            chk({tag, "_done"}, 64'(done_cnt - d0), 64'd0);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        ss    = 1'b1;
        addr  = 24'hABCDEF;
        data  = 16'h1234;
        outs  = 4'h5;
        u_if.UART_SEND_VALID_IN    = 1'b0;
        u_if.UART_SEND_BYTE_IN     = 8'h00;
        u_if.UART_RECEIVE_READY_IN = 1'b0;
        clks(3);

        chk("rst_send_ready", 64'(u_if.UART_SEND_READY), 64'd1);
        chk("rst_recv_valid", 64'(u_if.UART_RECEIVE_VALID), 64'd0);
        chk("rst_recv_byte", 64'(u_if.UART_RECEIVE_BYTE), 64'h0);
        chk("rst_input_sig", 64'(in_sig), 64'h0);
        chk("rst_overflow", 64'(ovf), 64'd0);
        chk("rst_frame_done", 64'(fdone), 64'd0);
        chk("rst_spiso_released", 64'(miso), 64'd1);
        rst_n = 1'b1;
        clks(4);

        // Idle frame: snapshot only
        frame("t1", mm(4'hA, 0, 0, 0, 8'h00), 56, 56'h00051234ABCDEF, 1);
        chk("t1_input_sig", 64'(in_sig), 64'hA);

        // Two queued bytes then an empty queue
        push(8'h41);
        push(8'h42);
        chk("t2_ready_2", 64'(u_if.UART_SEND_READY), 64'd1);
        frame("t2_f1", mm(4'hA, 0, 0, 0, 8'h00), 56, em(1, 0, 0, 8'h41), 1);
        frame("t2_f2", mm(4'hA, 0, 0, 0, 8'h00), 56, em(1, 0, 0, 8'h42), 1);
        frame("t2_f3", mm(4'hA, 0, 0, 0, 8'h00), 56, em(0, 0, 0, 8'h00), 1);

        // Fill the send FIFO; a fifth push is refused
        push(8'h60);
        push(8'h61);
        push(8'h62);
        chk("t2_ready_3", 64'(u_if.UART_SEND_READY), 64'd1);
        push(8'h63);
        chk("t2_ready_full", 64'(u_if.UART_SEND_READY), 64'd0);
        push(8'h64);

        // Short frame aborts
        frame("t3_abort", mm(4'h5, 0, 0, 0, 8'h00), 20, '0, 0);
        chk("t3_input_kept", 64'(in_sig), 64'hA);
        chk("t3_no_pop", 64'(u_if.UART_SEND_READY), 64'd0);

        // Head resent; host reports full
        frame("t3_resend", mm(4'h3, 0, 1, 0, 8'h00), 56, em(1, 0, 0, 8'h60), 1);
        chk("t3_input_sig", 64'(in_sig), 64'h3);
        chk("t3_popped", 64'(u_if.UART_SEND_READY), 64'd1);
        frame("t5_held", mm(4'h3, 0, 0, 0, 8'h00), 56, em(0, 0, 0, 8'h00), 1);
        frame("t5_resume", mm(4'h3, 0, 0, 0, 8'h00), 56, em(1, 0, 0, 8'h61), 1);
        frame("t5_b62", mm(4'h3, 0, 0, 0, 8'h00), 56, em(1, 0, 0, 8'h62), 1);
        frame("t5_b63", mm(4'h3, 0, 0, 0, 8'h00), 56, em(1, 0, 0, 8'h63), 1);
        frame("t5_empty", mm(4'h3, 0, 0, 0, 8'h00), 56, em(0, 0, 0, 8'h00), 1);

        // Host bytes fill the receive FIFO then overflow
        frame("t4_r1", mm(4'h3, 1, 0, 0, 8'h51), 56, em(0, 0, 0, 8'h00), 1);
        chk("t4_recv_valid", 64'(u_if.UART_RECEIVE_VALID), 64'd1);
        chk("t4_recv_head", 64'(u_if.UART_RECEIVE_BYTE), 64'h51);
        frame("t4_r2", mm(4'h3, 1, 0, 0, 8'h52), 56, em(0, 0, 0, 8'h00), 1);
        frame("t4_r3", mm(4'h3, 1, 0, 0, 8'h53), 56, em(0, 0, 0, 8'h00), 1);
        frame("t4_r4", mm(4'h3, 1, 0, 0, 8'h54), 56, em(0, 0, 0, 8'h00), 1);
        frame("t4_r5", mm(4'h3, 1, 0, 0, 8'h55), 56, em(0, 1, 0, 8'h00), 1);
        chk("t4_ovf_set", 64'(ovf), 64'd1);
        chk("t4_head_kept", 64'(u_if.UART_RECEIVE_BYTE), 64'h51);
        frame("t4_clr", mm(4'h3, 0, 0, 1, 8'h00), 56, em(0, 1, 1, 8'h00), 1);
        chk("t4_ovf_clr", 64'(ovf), 64'd0);

        u_if.UART_RECEIVE_READY_IN = 1'b1;
        clks(1);
        u_if.UART_RECEIVE_READY_IN = 1'b0;
        chk("t4_pop_head", 64'(u_if.UART_RECEIVE_BYTE), 64'h52);

        frame("t4_refill", mm(4'h3, 1, 0, 0, 8'h56), 56, em(0, 0, 0, 8'h00), 1);
        frame("t4_setclr", mm(4'h3, 1, 0, 1, 8'h57), 56, em(0, 1, 0, 8'h00), 1);
        chk("t4_set_wins", 64'(ovf), 64'd1);

        // Reset mid-frame with both FIFOs occupied
        push(8'h70);
        ss = 1'b0;
        clks(6);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
            clks(8);
        end
        rst_n = 1'b0;
        clks(2);
        chk("t6_send_ready", 64'(u_if.UART_SEND_READY), 64'd1);
        chk("t6_recv_valid", 64'(u_if.UART_RECEIVE_VALID), 64'd0);
        chk("t6_recv_byte", 64'(u_if.UART_RECEIVE_BYTE), 64'h0);
        chk("t6_input_sig", 64'(in_sig), 64'h0);
        chk("t6_overflow", 64'(ovf), 64'd0);
        chk("t6_frame_done", 64'(fdone), 64'd0);
        chk("t6_spiso_released", 64'(miso), 64'd1);
        ss = 1'b1;
        clks(4);
        rst_n = 1'b1;
        clks(4);
        frame("t6_after", mm(4'h0, 0, 0, 0, 8'h00), 56, em(0, 0, 0, 8'h00), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
